sdram_rd_checker: RTL

SDRAM_RD_CHECKER -- requirements
Module: sdram_rd_checker

---
 rtl/sdram_rd_checker.sv | 130 +++++++++++++
 1 files changed

// File: rtl/sdram_rd_checker.sv
// Checks one SDRAM read burst against an incrementing pattern from a seed; optional watchdog via SDRAM_RD_CHK_TIMEOUT_EN.
// o_done is registered, one cycle after the terminating beat/finish/timeout; never backpressures the controller.
module sdram_rd_checker #(
   parameter int SDR_DQ_WIDTH   = 16,
   parameter int BURST_LEN      = 8,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_start,
   input  logic [SDR_DQ_WIDTH-1:0] i_seed,
   input  logic [SDR_DQ_WIDTH-1:0] rd_burst_data,
   input  logic                    rd_burst_data_valid,
   input  logic                    rd_burst_finish,
   output logic                    o_busy,
   output logic                    o_done,
   output logic                    o_pass,
   output logic [7:0]              o_err_cnt,
   output logic [7:0]              o_first_err_beat,
   output logic [SDR_DQ_WIDTH-1:0] o_first_err_data,
   output logic [7:0]              o_beat_cnt,
   output logic                    o_timeout
);

   if (BURST_LEN < 1 || BURST_LEN > 255 || TIMEOUT_CYCLES < 2) begin : g_bad_param
      $error("sdram_rd_checker: BURST_LEN must be 1..255 and TIMEOUT_CYCLES >= 2");
   end

   localparam logic [7:0] BURST_LEN_B = 8'(BURST_LEN);

   typedef enum logic [1:0] {IDLE, ARMED, CHECK, DONE} state_t;

   state_t                  state;
   logic [SDR_DQ_WIDTH-1:0] expected;
   logic                    beat_take;
   logic                    beat_err;
   logic [7:0]              nxt_beat;
   logic [7:0]              nxt_err;
   logic                    last_beat;
   logic                    fin_hit;
   logic                    tmo_hit;
   logic                    to_done;
   logic                    nxt_pass;

   assign o_busy = (state == ARMED) || (state == CHECK);
   assign o_done = (state == DONE);

   always_comb begin
      beat_take = rd_burst_data_valid && o_busy;
      beat_err  = beat_take && (rd_burst_data != expected);
      nxt_beat  = o_beat_cnt + {7'd0, beat_take};
      nxt_err   = (beat_err && o_err_cnt != 8'hFF) ? o_err_cnt + 8'd1 : o_err_cnt;
      last_beat = beat_take && (nxt_beat == BURST_LEN_B);
      fin_hit   = rd_burst_finish && o_busy;
      to_done   = last_beat || fin_hit || tmo_hit;
      nxt_pass  = (nxt_err == 8'd0) && (nxt_beat == BURST_LEN_B) && !tmo_hit;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state            <= IDLE;
         expected         <= '0;
         o_pass           <= 1'b0;
         o_err_cnt        <= 8'd0;
         o_first_err_beat <= 8'd0;
         o_first_err_data <= '0;
         o_beat_cnt       <= 8'd0;
      end else begin
         case (state)
            IDLE: begin
               if (i_start) begin
                  state            <= ARMED;
                  expected         <= i_seed;
                  o_pass           <= 1'b0;
                  o_err_cnt        <= 8'd0;
                  o_first_err_beat <= 8'd0;
                  o_first_err_data <= '0;
                  o_beat_cnt       <= 8'd0;
               end
            end
            ARMED, CHECK: begin
               if (beat_take) begin
                  expected   <= expected + 1'b1;
                  o_beat_cnt <= nxt_beat;
                  o_err_cnt  <= nxt_err;
                  // first-error fields are 1-based beat indices, captured once
                  if (beat_err && o_err_cnt == 8'd0) begin
                     o_first_err_beat <= nxt_beat;
                     o_first_err_data <= rd_burst_data;
                  end
               end
               if (to_done) begin
                  state  <= DONE;
                  o_pass <= nxt_pass;
               end else if (beat_take) begin
                  state <= CHECK;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef SDRAM_RD_CHK_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [WD_W-1:0] wd_cnt;

   // hit fires on the idle cycle that would make the count reach the limit
   assign tmo_hit = o_busy && !beat_take && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wd_cnt    <= '0;
         o_timeout <= 1'b0;
      end else if (state == IDLE) begin
         wd_cnt <= '0;
         if (i_start) o_timeout <= 1'b0;
      end else if (o_busy) begin
         wd_cnt <= beat_take ? '0 : wd_cnt + 1'b1;
         if (tmo_hit) o_timeout <= 1'b1;
      end
   end
`else
   assign tmo_hit   = 1'b0;
   assign o_timeout = 1'b0;
`endif

endmodule
